bp_gshare: RTL

BP_GSHARE -- requirements
Module: bp_gshare

---
 rtl/bp_gshare_if.sv | 30 +++
 rtl/bp_gshare.sv | 100 ++++++++++
 2 files changed

// File: rtl/bp_gshare_if.sv
// Prediction/resolution bus between the fetch/commit pipeline and bp_gshare.
// The read side is combinational and has no handshake. r_pc is sampled every cycle, and
// r_* outputs are valid in the same cycle. The write side is made of single-cycle strobes
// (w_br_op, w_jal). Each strobe commits on the rising clock edge where it is high. There is
// no backpressure, so the predictor always accepts an update.
interface bp_gshare_if #(
  parameter int H_LEN = 6
) ();
  logic [31:0]      r_pc;
  logic [31:0]      r_addr_pred;
  logic             r_taken_pred;
  logic             r_hit;
  logic [H_LEN-1:0] r_ghr;
  logic             w_br_op;
  logic             w_jal;
  logic [31:0]      w_pc;
  logic [31:0]      w_dest;
  logic             w_taken;
  logic [H_LEN-1:0] w_ghr;

  modport master (
    output r_pc, w_br_op, w_jal, w_pc, w_dest, w_taken, w_ghr,
    input  r_addr_pred, r_taken_pred, r_hit, r_ghr
  );

  modport slave (
    input  r_pc, w_br_op, w_jal, w_pc, w_dest, w_taken, w_ghr,
    output r_addr_pred, r_taken_pred, r_hit, r_ghr
  );
endinterface

// File: rtl/bp_gshare.sv
// Branch predictor: direct-mapped BTB plus a PHT of saturating counters.
// The PHT is indexed bimodally or by gshare (PC xor non-speculative global history).
module bp_gshare #(
  parameter int s_index = 4,
  parameter int s_pht   = 6,
  parameter int width   = 2,
  parameter int h_len   = 6,
  parameter int mode    = 1
) (
  input logic       clk,
  input logic       rst,
  bp_gshare_if.slave bus
);
  localparam int BTB_N = 1 << s_index;
  localparam int PHT_N = 1 << s_pht;
  localparam int TAG_W = 30 - s_index;

  typedef logic [s_index-1:0] btb_idx_t;
  typedef logic [s_pht-1:0]   pht_idx_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [width-1:0]   ctr_t;

  localparam ctr_t CTR_INIT = ctr_t'((1 << (width - 1)) - 1);
  localparam ctr_t CTR_MAX  = '1;

  logic [BTB_N-1:0] valid_q;
  logic [BTB_N-1:0] uncond_q;
  tag_t             tag_q    [BTB_N];
  logic [31:0]      target_q [BTB_N];
  ctr_t             pht_q    [PHT_N];
  logic [h_len-1:0] ghr_q, ghr_d, ghr_shift;

  btb_idx_t rd_btb_idx, wr_btb_idx;
  tag_t     rd_tag, wr_tag;
  pht_idx_t rd_pht_idx, wr_pht_idx;
  ctr_t     ctr_cur, ctr_d;
  logic     do_jal, do_br, btb_we;
  logic     unused_pc_bits;

  assign unused_pc_bits = ^{bus.r_pc[1:0], bus.w_pc[1:0]};

  // Read path: purely combinational from r_pc and current state.
  always_comb begin
    rd_btb_idx = bus.r_pc[s_index+1:2];
    rd_tag     = bus.r_pc[31:s_index+2];
    rd_pht_idx = bus.r_pc[s_pht+1:2] ^ ((mode != 0) ? pht_idx_t'(ghr_q) : '0);
  end

  assign bus.r_hit        = valid_q[rd_btb_idx] && (tag_q[rd_btb_idx] == rd_tag);
  assign bus.r_addr_pred  = bus.r_hit ? target_q[rd_btb_idx] : 32'd0;
  assign bus.r_taken_pred = bus.r_hit && (uncond_q[rd_btb_idx] || pht_q[rd_pht_idx][width-1]);
  assign bus.r_ghr        = ghr_q;

  // A JAL takes priority over a simultaneous conditional-branch strobe.
  always_comb begin
    do_jal     = bus.w_jal;
    do_br      = bus.w_br_op && !bus.w_jal;
    btb_we     = do_jal || (do_br && bus.w_taken);
    wr_btb_idx = bus.w_pc[s_index+1:2];
    wr_tag     = bus.w_pc[31:s_index+2];
    wr_pht_idx = bus.w_pc[s_pht+1:2] ^ ((mode != 0) ? pht_idx_t'(bus.w_ghr) : '0);
    ctr_cur    = pht_q[wr_pht_idx];
    ctr_d      = ctr_cur;
    if (bus.w_taken && (ctr_cur != CTR_MAX)) begin
      ctr_d = ctr_cur + ctr_t'(1);
    end else if (!bus.w_taken && (ctr_cur != '0)) begin
      ctr_d = ctr_cur - ctr_t'(1);
    end
    ghr_shift    = ghr_q << 1;
    ghr_shift[0] = bus.w_taken;
    ghr_d        = do_br ? ghr_shift : ghr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else begin
      if (btb_we) begin
        valid_q[wr_btb_idx] <= 1'b1;
      end
      if (do_br) begin
        pht_q[wr_pht_idx] <= ctr_d;
      end
      ghr_q <= ghr_d;
    end
  end

  // BTB payload needs no reset; valid_q alone decides visibility.
  always_ff @(posedge clk) begin
    if (btb_we && !rst) begin
      uncond_q[wr_btb_idx] <= do_jal;
      tag_q[wr_btb_idx]    <= wr_tag;
      target_q[wr_btb_idx] <= bus.w_dest;
    end
  end
endmodule
